// File: rtl/gray_counter.sv
// Free-running Gray-code counter with count enable and a sticky wrap flag.
// The Gray code is registered directly so the output never glitches between edges.
module gray_counter #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] gray_r;
  logic             ovf_r;
  logic             wrap_s;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next binary count and wrap detection
  always_comb begin
    cnt_nxt_s = cnt_r;
    wrap_s    = 1'b0;
    if (En) begin
      cnt_nxt_s = cnt_r + WIDTH'(1);
      wrap_s    = (cnt_r == {WIDTH{1'b1}});
    end else begin
      cnt_nxt_s = cnt_r;
      wrap_s    = 1'b0;
    end
  end

  // Count, Gray image and sticky flag registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r  <= {WIDTH{1'b0}};
      gray_r <= {WIDTH{1'b0}};
      ovf_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      // Gray is encoded from the next count, so it tracks cnt_r with no extra latency
      gray_r <= bin2gray(cnt_nxt_s);
      ovf_r  <= ovf_r | wrap_s;
    end
  end

  assign Output   = gray_r;
  assign Overflow = ovf_r;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (WIDTH = 3).
module tb_gray_counter;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Output;
  logic       Overflow;

  int n_cmp;
  int n_err;

  logic [2:0] seq [8];
  logic [2:0] prev;

  gray_counter #(.WIDTH(3)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Output   (Output),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [2:0] exp_g, input logic exp_o);
    tick();
    chk({tag, "_out"}, Output, exp_g);
    chk({tag, "_ovf"}, {2'b00, Overflow}, {2'b00, exp_o});
    chk({tag, "_onebit"}, 3'($countones(prev ^ Output)), 3'd1);
    prev = Output;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
    seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;

    // Reset held low with En high for 3 edges
    Reset = 1'b0;
    En    = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_out", Output, 3'b000);
      chk("rst_hold_ovf", {2'b00, Overflow}, 3'b000);
    end
    Reset = 1'b1;
    prev  = 3'b000;

    // First pass: 8 edges, overflow only after the 8th
    for (int i = 1; i <= 8; i++)
      step_chk("pass1", seq[i % 8], (i == 8));

    // Second pass: 9 edges, overflow stays set across the second wrap
    for (int i = 1; i <= 9; i++)
      step_chk("pass2", seq[i % 8], 1'b1);

    // Now at 001; advance to 011 then hold with En low
    step_chk("to011", 3'b011, 1'b1);
    En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_out", Output, 3'b011);
      chk("hold_ovf", {2'b00, Overflow}, 3'b001);
    end
    // En pulse between edges must be ignored
    #2 En = 1'b1;
    #2 En = 1'b0;
    tick();
    chk("glitch_en_out", Output, 3'b011);
    En = 1'b1;
    step_chk("reenable", 3'b010, 1'b1);
    step_chk("to110", 3'b110, 1'b1);
    step_chk("to111", 3'b111, 1'b1);

    // Asynchronous reset between edges at 111 / overflow set
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_out", Output, 3'b000);
    chk("async_rst_ovf", {2'b00, Overflow}, 3'b000);
    tick();
    chk("async_hold_out", Output, 3'b000);
    Reset = 1'b1;
    prev  = 3'b000;

    // Count up to 100, then assert reset on the wrap edge
    for (int i = 1; i <= 7; i++)
      step_chk("pass3", seq[i], 1'b0);
    @(posedge Clk);
    Reset = 1'b0;
    #1;
    chk("wrap_rst_out", Output, 3'b000);
    chk("wrap_rst_ovf", {2'b00, Overflow}, 3'b000);
    tick();
    chk("wrap_rst_hold", Output, 3'b000);
    Reset = 1'b1;
    prev  = 3'b000;
    step_chk("after_rst", 3'b001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
